// File: rtl/sstv_vis_gen.sv
// SSTV VIS header generator: start bit, 7 data bits LSB first, even parity, stop bit.
// Each bit holds one registered tone code on freq for T clocks.
module sstv_vis_gen #(
  parameter bit simulate = 1'b0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [6:0]  vis_code,
  input  logic        abort,
  output logic [11:0] freq,
  output logic        busy,
  output logic        done
);

  localparam logic [31:0] T      = simulate ? 32'd3_000 : 32'd3_000_000;
  localparam logic [11:0] F_OFF  = 12'd0;
  localparam logic [11:0] F_ONE  = 12'd1100;
  localparam logic [11:0] F_SYNC = 12'd1200;
  localparam logic [11:0] F_ZERO = 12'd1300;

  typedef enum logic [3:0] {
    IDLE  = 4'b0001,
    START = 4'b0010,
    DATA  = 4'b0100,
    STOP  = 4'b1000
  } state_t;

  state_t      state_q, state_d;
  logic [11:0] freq_d;
  logic        busy_d, done_d;
  logic [3:0]  bit_cnt_q, bit_cnt_d;
  logic [31:0] dly_q, dly_d;
  logic [7:0]  shreg_q, shreg_d;
  logic        bit_end;

  function automatic logic [11:0] tone(input logic b);
    return b ? F_ONE : F_ZERO;
  endfunction

  function automatic logic parity7(input logic [6:0] c);
    return ^c;
  endfunction

  assign bit_end = (dly_q == T);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      freq      <= F_OFF;
      busy      <= 1'b0;
      done      <= 1'b0;
      bit_cnt_q <= 4'd0;
      dly_q     <= 32'd1;
      shreg_q   <= 8'd0;
    end else begin
      state_q   <= state_d;
      freq      <= freq_d;
      busy      <= busy_d;
      done      <= done_d;
      bit_cnt_q <= bit_cnt_d;
      dly_q     <= dly_d;
      shreg_q   <= shreg_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    freq_d    = freq;
    busy_d    = busy;
    done_d    = 1'b0;
    bit_cnt_d = bit_cnt_q;
    dly_d     = dly_q;
    shreg_d   = shreg_q;

    // Bit timer runs in every emitting state and wraps on each bit boundary
    if (state_q != IDLE) begin
      dly_d = bit_end ? 32'd1 : dly_q + 32'd1;
    end

    case (state_q)
      IDLE: begin
        freq_d = F_OFF;
        busy_d = 1'b0;
        if (start && !abort) begin
          shreg_d   = {parity7(vis_code), vis_code};
          bit_cnt_d = 4'd0;
          dly_d     = 32'd1;
          state_d   = START;
          freq_d    = F_SYNC;
          busy_d    = 1'b1;
        end
      end
      START: begin
        if (bit_end) begin
          state_d = DATA;
          freq_d  = tone(shreg_q[0]);
        end
      end
      DATA: begin
        if (bit_end) begin
          shreg_d   = {1'b0, shreg_q[7:1]};
          bit_cnt_d = bit_cnt_q + 4'd1;
          // Next tone is loaded together with the shift so it lands on the boundary
          if (bit_cnt_q == 4'd7) begin
            state_d = STOP;
            freq_d  = F_SYNC;
          end else begin
            freq_d  = tone(shreg_q[1]);
          end
        end
      end
      STOP: begin
        if (bit_end) begin
          state_d = IDLE;
          freq_d  = F_OFF;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        freq_d  = F_OFF;
        busy_d  = 1'b0;
      end
    endcase

    if (abort && (state_q != IDLE)) begin
      state_d = IDLE;
      freq_d  = F_OFF;
      busy_d  = 1'b0;
      done_d  = 1'b0;
      dly_d   = 32'd1;
    end
  end

endmodule

// File: tb/tb_sstv_vis_gen.sv
// Bench for sstv_vis_gen: random and directed VIS headers checked against a tone-table model.
module tb_sstv_vis_gen;

  localparam int T = 3000;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [6:0]  vis_code;
  logic        abort;
  logic [11:0] freq;
  logic        busy;
  logic        done;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  sstv_vis_gen #(.simulate(1'b1)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (start),
    .vis_code (vis_code),
    .abort    (abort),
    .freq     (freq),
    .busy     (busy),
    .done     (done)
  );

  // Tone expected pos cycles after the first start-bit cycle of a header
  function automatic logic [11:0] exp_freq(input logic [6:0] code, input int pos);
    int b;
    b = pos / T;
    if (pos >= 10 * T) return 12'd0;
    if (b == 0 || b == 9) return 12'd1200;
    if (b == 8) return ($countones(code) % 2 == 1) ? 12'd1100 : 12'd1300;
    return code[b - 1] ? 12'd1100 : 12'd1300;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Walks header positions [from,to), one verdict per bit window
  task automatic emit(input string tag, input logic [6:0] code, input int from, input int to,
                      input bit noise);
    int          bad;
    logic [11:0] f_obs, f_exp;
    logic        b_obs, d_obs;
    bad = 0;
    f_obs = '0; f_exp = '0; b_obs = 1'b0; d_obs = 1'b0;
    for (int p = from; p < to; p++) begin
      logic [11:0] ef;
      logic        eb, ed;
      ef = exp_freq(code, p);
      eb = (p < 10 * T);
      ed = (p == 10 * T);
      if (freq !== ef || busy !== eb || done !== ed || !$onehot(dut.state_q)) begin
        if (bad == 0) begin
          f_obs = freq; f_exp = ef; b_obs = busy; d_obs = done;
        end
        bad++;
      end
      if ((p + 1) / T != p / T || p == to - 1) begin
        checks++;
        assert (bad === 0) else begin
          errors++;
          $error("FAIL %s bit%0d: %0d bad cycles, observed freq=%0d busy=%0b done=%0b expected freq=%0d",
                 tag, p / T, bad, f_obs, b_obs, d_obs, f_exp);
        end
        bad = 0;
      end
      if (noise && (p == 5000 || p == 20000)) begin
        start    = 1'b1;
        vis_code = 7'($urandom);
      end
      tick();
      start = 1'b0;
    end
  endtask

  initial begin
    logic [6:0] code;
    reset_n  = 1'b0;
    start    = 1'b0;
    abort    = 1'b0;
    vis_code = 7'd0;
    #12;
    check("reset freq", 32'(freq), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    check("idle freq", 32'(freq), 32'd0);
    check("idle busy", 32'(busy), 32'd0);

    // Martin M1 with ignored start requests mid-header
    vis_code = 7'h2C;
    start    = 1'b1;
    tick();
    start = 1'b0;
    emit("m1", 7'h2C, 0, 10 * T, 1'b1);
    check("m1 done", 32'(done), 32'd1);
    check("m1 end freq", 32'(freq), 32'd0);
    check("m1 end busy", 32'(busy), 32'd0);

    // Back-to-back start accepted in the done cycle
    vis_code = 7'h08;
    start    = 1'b1;
    tick();
    start = 1'b0;
    emit("b2b", 7'h08, 0, 10 * T + 1, 1'b0);
    check("b2b done low", 32'(done), 32'd0);
    check("b2b idle freq", 32'(freq), 32'd0);
    tick();
    check("b2b idle busy", 32'(busy), 32'd0);

    // Abort mid-header at random code
    code     = 7'($urandom);
    vis_code = code;
    start    = 1'b1;
    tick();
    start = 1'b0;
    emit("pre-abort", code, 0, 12000, 1'b0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort freq", 32'(freq), 32'd0);
    check("abort busy", 32'(busy), 32'd0);
    check("abort done", 32'(done), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("abort no done", 32'(done), 32'd0);
    end
    start    = 1'b1;
    abort    = 1'b1;
    vis_code = 7'($urandom);
    tick();
    start = 1'b0;
    abort = 1'b0;
    check("abort wins busy", 32'(busy), 32'd0);
    check("abort wins freq", 32'(freq), 32'd0);

    // Scottie S1, then asynchronous reset between edges in DATA
    vis_code = 7'h3C;
    start    = 1'b1;
    tick();
    start = 1'b0;
    emit("s1", 7'h3C, 0, 14500, 1'b0);
    check("s1 pre-reset busy", 32'(busy), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check("async rst freq", 32'(freq), 32'd0);
    check("async rst busy", 32'(busy), 32'd0);
    check("async rst done", 32'(done), 32'd0);
    #20;
    reset_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("post-rst freq", 32'(freq), 32'd0);
      check("post-rst busy", 32'(busy), 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
